// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_e   : transaction FSM states (2 bits)
//   OwnIf / OwnDm : owner encoding, also the requester index into the picker
//   MemLatency*   : legal range of the fixed memory read latency
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  localparam logic OwnIf = 1'b0;
  localparam logic OwnDm = 1'b1;

  localparam int unsigned MemLatencyMin = 1;
  localparam int unsigned MemLatencyMax = 15;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker.
//   req_i[1:0]    : request vector, index OwnIf / OwnDm
//   last_i        : index of the previous owner
//   grant_valid_o : at least one request is pending
//   grant_idx_o   : index of the selected requester
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  always_comb begin
    grant_valid_o = |req_i;
    // A lone request wins outright; index 1 is set only when req_i[1] is.
    grant_idx_o   = req_i[1];
    // On a tie the requester that did not own the port last time wins.
    if (req_i == 2'b11) begin
      grant_idx_o = ~last_i;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and data (DM).
// Round-robin on ties, one transaction in flight, fixed read latency.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   start_i               : allows new grants; in-flight accesses always finish
//   if_req_i/if_addr_i    : fetch request, held until if_ack_o
//   if_ack_o/if_rdata_o   : one-cycle done pulse, fetched word
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i : data request, held until dm_ack_o
//   dm_ack_o/dm_rdata_o   : one-cycle done pulse, load data
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o : registered memory strobe and command
//   mem_rdata_i           : read data, valid MEM_LATENCY cycles after mem_en_o
//   busy_o                : high whenever the FSM is not idle
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  if (MEM_LATENCY < MemLatencyMin || MEM_LATENCY > MemLatencyMax) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY out of range 1..15");
  end

  localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_LATENCY - 1);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_buf_q, rdata_buf_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic pick_valid;
  logic pick_idx;

  rr_pick2 u_pick (
    .req_i         ({dm_req_i, if_req_i}),
    .last_i        (last_owner_q),
    .grant_valid_o (pick_valid),
    .grant_idx_o   (pick_idx)
  );

  // The mem_* registers double as the latched request: they are loaded once at
  // grant and hold for the rest of the transaction.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_buf_d  = rdata_buf_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    case (state_q)
      StIdle: begin
        if (start_i && pick_valid) begin
          owner_d  = pick_idx;
          mem_en_d = 1'b1;
          if (pick_idx == OwnDm) begin
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr_i;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (mem_we_q) begin
          state_d = StResp;
        end else begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          rdata_buf_d = mem_rdata_i;
          state_d     = StResp;
        end
      end
      StResp: begin
        last_owner_d = owner_q;
        if (!mem_we_q) begin
          if (owner_q == OwnIf) begin
            if_rdata_d = rdata_buf_q;
          end else begin
            dm_rdata_d = rdata_buf_q;
          end
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      owner_q      <= OwnIf;
      last_owner_q <= OwnIf;
      cnt_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_buf_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_buf_q  <= rdata_buf_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  always_comb begin
    busy_o      = (state_q != StIdle);
    if_ack_o    = (state_q == StResp) && (owner_q == OwnIf);
    dm_ack_o    = (state_q == StResp) && (owner_q == OwnDm);
    // Captured data is visible during the ack cycle itself, then held.
    if_rdata_o  = if_ack_o ? rdata_buf_q : if_rdata_q;
    dm_rdata_o  = (dm_ack_o && !mem_we_q) ? rdata_buf_q : dm_rdata_q;
    mem_en_o    = mem_en_q;
    mem_we_o    = mem_we_q;
    mem_addr_o  = mem_addr_q;
    mem_wdata_o = mem_wdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam bit OWN_IF = 1'b0;
  localparam bit OWN_DM = 1'b1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start, if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;

  logic        if_ack [3];
  logic        dm_ack [3];
  logic        mem_en [3];
  logic        mem_we [3];
  logic        busy   [3];
  logic [31:0] if_rdata  [3];
  logic [31:0] dm_rdata  [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          own;
    bit          chk_data;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t sb [3][$];
  logic [31:0] wr_map [logic [31:0]];

  int en_cnt = 0;
  int overlap_cnt = 0;
  always @(negedge clk) begin
    if (mem_en[0]) en_cnt <= en_cnt + 1;
    if (if_ack[0] && dm_ack[0]) overlap_cnt <= overlap_cnt + 1;
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction

  // Instance 0 uses latency 2; instances 1 and 2 use 1 and 4. All share stimulus.
  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int unsigned L = (k == 0) ? 2 : (k == 1) ? 1 : 4;
    logic [31:0] mem [1024];
    logic [31:0] pipe_d [16];
    logic        pipe_v [16];

    initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 4) ^ 32'hA5A5_0000;
      for (int i = 0; i < 16; i++) begin
        pipe_v[i] = 1'b0;
        pipe_d[i] = '0;
      end
    end

    always @(posedge clk) begin
      if (mem_en[k] && mem_we[k]) mem[mem_addr[k][11:2]] <= mem_wdata[k];
      pipe_v[0] <= mem_en[k] && !mem_we[k];
      pipe_d[0] <= mem[mem_addr[k][11:2]];
      for (int i = 1; i < 16; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end

    assign mem_rdata[k] = pipe_v[L-1] ? pipe_d[L-1] : 32'hBAD0_BAD0;

    mem_port_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .MEM_LATENCY (L)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .if_req_i    (if_req),
      .if_addr_i   (if_addr),
      .if_ack_o    (if_ack[k]),
      .if_rdata_o  (if_rdata[k]),
      .dm_req_i    (dm_req),
      .dm_we_i     (dm_we),
      .dm_addr_i   (dm_addr),
      .dm_wdata_i  (dm_wdata),
      .dm_ack_o    (dm_ack[k]),
      .dm_rdata_o  (dm_rdata[k]),
      .mem_en_o    (mem_en[k]),
      .mem_we_o    (mem_we[k]),
      .mem_addr_o  (mem_addr[k]),
      .mem_wdata_o (mem_wdata[k]),
      .mem_rdata_i (mem_rdata[k]),
      .busy_o      (busy[k])
    );
  end

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (wr_map.exists(a)) return wr_map[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic push_exp(input int k, input bit own, input bit chk, input logic [31:0] d,
                          input int at);
    exp_t e;
    e.own = own;
    e.chk_data = chk;
    e.data = d;
    e.at = at;
    sb[k].push_back(e);
  endtask

  // Waits for the next ack on instance k, sampling on falling edges.
  task automatic wait_ack(input int k, input int bound, output bit found, output bit own,
                          output logic [31:0] data, output int at);
    found = 1'b0;
    own = 1'b0;
    data = '0;
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (if_ack[k] || dm_ack[k]) begin
        found = 1'b1;
        own = dm_ack[k];
        data = dm_ack[k] ? dm_rdata[k] : if_rdata[k];
        at = cyc;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b0;
    dm_req = 1'b0;
    dm_we = 1'b0;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) sb[k].delete();
  endtask

  task automatic test_reset();
    start = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({if_ack[k], dm_ack[k], mem_en[k], mem_we[k], busy[k]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctl[%0d]: got %b, wanted 00000", k,
                 {if_ack[k], dm_ack[k], mem_en[k], mem_we[k], busy[k]});
      end
      checks++;
      if ({mem_addr[k], mem_wdata[k], if_rdata[k], dm_rdata[k]} !== 128'h0) begin
        errors++;
        $display("FAIL reset_data[%0d]: got %h %h %h %h, wanted all zero", k, mem_addr[k],
                 mem_wdata[k], if_rdata[k], dm_rdata[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_if_read();
    int t0, at;
    bit found, own;
    logic [31:0] d;
    exp_t e;
    @(negedge clk);
    t0 = cyc;
    if_req = 1'b1;
    if_addr = 32'h10;
    push_exp(0, OWN_IF, 1'b1, exp_rd(32'h10), t0 + 4);
    @(negedge clk);
    checks++;
    if ({mem_en[0], mem_we[0], busy[0]} !== 3'b101 || mem_addr[0] !== 32'h10) begin
      errors++;
      $display("FAIL if_read_issue: got en/we/busy=%b addr=%h, wanted 101 addr=00000010",
               {mem_en[0], mem_we[0], busy[0]}, mem_addr[0]);
    end
    wait_ack(0, 10, found, own, d, at);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL if_read_ack: got no ack, wanted ack at cycle %0d", t0 + 4);
    end else begin
      e = sb[0].pop_front();
      if (own !== e.own || d !== e.data || at !== e.at || busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL if_read_ack: got own=%0d data=%h cyc=%0d busy=%b, wanted %0d %h %0d 1",
                 own, d, at, busy[0], e.own, e.data, e.at);
      end
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || if_rdata[0] !== 32'hA5A5_0010 || if_ack[0] !== 1'b0) begin
      errors++;
      $display("FAIL if_read_after: got busy=%b ack=%b rdata=%h, wanted 0 0 a5a50010",
               busy[0], if_ack[0], if_rdata[0]);
    end
  endtask

  task automatic test_tie();
    int t0, at;
    bit found, own;
    logic [31:0] d;
    exp_t e;
    do_reset();
    @(negedge clk);
    t0 = cyc;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
    if_req = 1'b1; if_addr = 32'h30;
    push_exp(0, OWN_DM, 1'b1, exp_rd(32'h20), t0 + 4);
    push_exp(0, OWN_IF, 1'b1, exp_rd(32'h30), t0 + 9);
    for (int n = 0; n < 2; n++) begin
      wait_ack(0, 15, found, own, d, at);
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL tie_ack%0d: got no ack, wanted one", n);
      end else begin
        e = sb[0].pop_front();
        if (own !== e.own || d !== e.data || at !== e.at) begin
          errors++;
          $display("FAIL tie_ack%0d: got own=%0d data=%h cyc=%0d, wanted %0d %h %0d", n, own,
                   d, at, e.own, e.data, e.at);
        end
        if (own) dm_req = 1'b0;
        else if_req = 1'b0;
      end
    end
  endtask

  task automatic test_contention();
    int t0, at, en0;
    bit found, own;
    logic [31:0] d;
    exp_t e;
    @(negedge clk);
    t0 = cyc;
    en0 = en_cnt;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h200;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) push_exp(0, OWN_DM, 1'b1, exp_rd(32'h100 + 32'(16 * (i / 2))), t0 + 4 + 5 * i);
      else push_exp(0, OWN_IF, 1'b1, exp_rd(32'h200 + 32'(16 * (i / 2))), t0 + 4 + 5 * i);
    end
    for (int i = 0; i < 8; i++) begin
      wait_ack(0, 12, found, own, d, at);
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL contention_ack%0d: got no ack, wanted one", i);
        break;
      end
      e = sb[0].pop_front();
      if (own !== e.own || d !== e.data || at !== e.at) begin
        errors++;
        $display("FAIL contention_ack%0d: got own=%0d data=%h cyc=%0d, wanted %0d %h %0d", i,
                 own, d, at, e.own, e.data, e.at);
      end
      if (own) dm_addr = dm_addr + 32'h10;
      else if_addr = if_addr + 32'h10;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    sb[0].delete();
    repeat (3) @(negedge clk);
    checks++;
    if (en_cnt - en0 !== 8 || overlap_cnt !== 0) begin
      errors++;
      $display("FAIL contention_strobes: got en=%0d overlap=%0d, wanted 8 0", en_cnt - en0,
               overlap_cnt);
    end
  endtask

  task automatic test_dm_write();
    int t0, at;
    bit found, own;
    logic [31:0] d;
    exp_t e;
    @(negedge clk);
    t0 = cyc;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
    wr_map[32'h40] = 32'hDEAD_BEEF;
    push_exp(0, OWN_DM, 1'b0, '0, t0 + 2);
    @(negedge clk);
    checks++;
    if ({mem_en[0], mem_we[0]} !== 2'b11 || mem_addr[0] !== 32'h40 ||
        mem_wdata[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_issue: got en/we=%b addr=%h wdata=%h, wanted 11 00000040 deadbeef",
               {mem_en[0], mem_we[0]}, mem_addr[0], mem_wdata[0]);
    end
    wait_ack(0, 6, found, own, d, at);
    checks++;
    e = sb[0].pop_front();
    if (!found || own !== e.own || at !== e.at) begin
      errors++;
      $display("FAIL write_ack: got found=%0d own=%0d cyc=%0d, wanted 1 %0d %0d", found, own,
               at, e.own, e.at);
    end
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h40;
    push_exp(0, OWN_IF, 1'b1, exp_rd(32'h40), t0 + 4);
    @(negedge clk);
    checks++;
    if ({mem_en[0], mem_we[0]} !== 2'b10) begin
      errors++;
      $display("FAIL raw_issue: got en/we=%b, wanted 10", {mem_en[0], mem_we[0]});
    end
    wait_ack(0, 10, found, own, d, at);
    checks++;
    e = sb[0].pop_front();
    if (!found || own !== e.own || d !== e.data || at !== e.at) begin
      errors++;
      $display("FAIL raw_ack: got found=%0d own=%0d data=%h cyc=%0d, wanted 1 %0d %h %0d",
               found, own, d, at, e.own, e.data, e.at);
    end
    if_req = 1'b0;
  endtask

  task automatic test_start_drop();
    int t0, at, bad;
    bit found, own;
    logic [31:0] d;
    exp_t e;
    @(negedge clk);
    t0 = cyc;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h50;
    if_req = 1'b1; if_addr = 32'h60;
    push_exp(0, OWN_DM, 1'b1, exp_rd(32'h50), t0 + 4);
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_ack(0, 8, found, own, d, at);
    checks++;
    e = sb[0].pop_front();
    if (!found || own !== e.own || d !== e.data || at !== e.at) begin
      errors++;
      $display("FAIL start_drop_ack: got found=%0d own=%0d data=%h cyc=%0d, wanted 1 %0d %h %0d",
               found, own, d, at, e.own, e.data, e.at);
    end
    dm_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy[0] || mem_en[0] || if_ack[0]) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL start_low_idle: got %0d active cycles, wanted 0", bad);
    end
    @(negedge clk);
    t0 = cyc;
    start = 1'b1;
    push_exp(0, OWN_IF, 1'b1, exp_rd(32'h60), t0 + 4);
    wait_ack(0, 10, found, own, d, at);
    checks++;
    e = sb[0].pop_front();
    if (!found || own !== e.own || d !== e.data || at !== e.at) begin
      errors++;
      $display("FAIL start_resume_ack: got found=%0d own=%0d data=%h cyc=%0d, wanted 1 %0d %h %0d",
               found, own, d, at, e.own, e.data, e.at);
    end
    if_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t0, acks;
    int got [3];
    logic [31:0] d;
    exp_t e;
    // Make DM the last owner everywhere; the request drops right after its grant.
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h70;
    @(negedge clk);
    dm_req = 1'b0;
    repeat (10) @(negedge clk);
    // Tie now goes to IF; abort it in WAIT.
    dm_req = 1'b1; dm_addr = 32'h74;
    if_req = 1'b1; if_addr = 32'h80;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dm_req = 1'b0;
    if_req = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({if_ack[k], dm_ack[k], mem_en[k], mem_we[k], busy[k]} !== 5'b0 ||
          {mem_addr[k], mem_wdata[k], if_rdata[k], dm_rdata[k]} !== 128'h0) begin
        errors++;
        $display("FAIL async_reset[%0d]: got ctl=%b addr=%h rd=%h/%h, wanted all zero", k,
                 {if_ack[k], dm_ack[k], mem_en[k], mem_we[k], busy[k]}, mem_addr[k],
                 if_rdata[k], dm_rdata[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) sb[k].delete();
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (if_ack[k] || dm_ack[k] || mem_en[k]) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL abort_no_ack: got %0d ack/strobe cycles, wanted 0", acks);
    end
    t0 = cyc;
    dm_req = 1'b1; dm_addr = 32'h90;
    if_req = 1'b1; if_addr = 32'hA0;
    for (int k = 0; k < 3; k++) begin
      got[k] = 0;
      push_exp(k, OWN_DM, 1'b1, exp_rd(32'h90), t0 + lat_of(k) + 2);
      push_exp(k, OWN_IF, 1'b1, exp_rd(32'hA0), t0 + 2 * lat_of(k) + 5);
    end
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if ((if_ack[k] || dm_ack[k]) && got[k] < 2) begin
          e = sb[k].pop_front();
          got[k]++;
          d = dm_ack[k] ? dm_rdata[k] : if_rdata[k];
          checks++;
          if (dm_ack[k] !== e.own || d !== e.data || cyc !== e.at) begin
            errors++;
            $display("FAIL lat%0d_ack%0d: got own=%0d data=%h cyc=%0d, wanted %0d %h %0d",
                     lat_of(k), got[k], dm_ack[k], d, cyc, e.own, e.data, e.at);
          end
        end
      end
    end
    dm_req = 1'b0;
    if_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got[k] !== 2) begin
        errors++;
        $display("FAIL lat%0d_count: got %0d acks, wanted 2", lat_of(k), got[k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, wanted finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_if_read();
    test_tie();
    test_contention();
    test_dm_write();
    test_start_drop();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
